// File: rtl/cmul_seq.sv
// Sequential complex-multiply block controller: fetches a+jb and a twiddle c+jd per op,
// drives an external 4-product multiplier and emits (ac-bd) + j(bc+ad) with a valid/ready handshake.
module cmul_seq #(
    parameter int LOGN = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [LOGN:0]   op_len,
    input  logic [LOGN-1:0] tw_step,
    output logic [LOGN-1:0] rd_addr,
    output logic [LOGN-1:0] tw_addr,
    output logic            cm_en,
    input  logic [38:0]     cm_out1,
    input  logic [38:0]     cm_out2,
    input  logic [38:0]     cm_out3,
    input  logic [38:0]     cm_out4,
    output logic [39:0]     res_re,
    output logic [39:0]     res_im,
    output logic [LOGN-1:0] res_addr,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            busy,
    output logic            done
);

    localparam logic [LOGN:0] N_PTS = {1'b1, {LOGN{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_EN   = 3'd2,
        S_WAIT = 3'd3,
        S_CAPT = 3'd4,
        S_OUT  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [LOGN:0]   r_i;
    logic [LOGN-1:0] r_t;
    logic [LOGN:0]   r_len;
    logic [LOGN-1:0] r_step;
    logic [LOGN-1:0] r_rd_addr;
    logic [LOGN-1:0] r_tw_addr;
    logic [39:0]     r_res_re;
    logic [39:0]     r_res_im;
    logic [LOGN-1:0] r_res_addr;

    logic [LOGN:0]   w_len_clamp;
    logic [LOGN:0]   w_i_nxt;
    logic [LOGN-1:0] w_t_nxt;

    assign w_len_clamp = (op_len > N_PTS) ? N_PTS : op_len;
    assign w_i_nxt     = r_i + {{LOGN{1'b0}}, 1'b1};
    // Twiddle index wraps modulo N through natural LOGN-bit overflow.
    assign w_t_nxt     = r_t + r_step;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_len_clamp == {(LOGN+1){1'b0}}) ? S_DONE : S_ADDR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ADDR: w_next = S_EN;
            S_EN:   w_next = S_WAIT;
            S_WAIT: w_next = S_CAPT;
            S_CAPT: w_next = S_OUT;
            S_OUT: begin
                if (res_ready) begin
                    w_next = (w_i_nxt < r_len) ? S_ADDR : S_DONE;
                end else begin
                    w_next = S_OUT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        cm_en     = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE:  busy      = 1'b0;
            S_EN:    cm_en     = 1'b1;
            S_OUT:   res_valid = 1'b1;
            S_DONE:  done      = 1'b1;
            default: busy      = 1'b1;
        endcase
    end

    // Datapath: block parameters, op/twiddle indices, addresses and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i        <= '0;
            r_t        <= '0;
            r_len      <= '0;
            r_step     <= '0;
            r_rd_addr  <= '0;
            r_tw_addr  <= '0;
            r_res_re   <= '0;
            r_res_im   <= '0;
            r_res_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len  <= w_len_clamp;
                        r_step <= tw_step;
                        r_i    <= '0;
                        r_t    <= '0;
                        if (w_next == S_ADDR) begin
                            r_rd_addr <= '0;
                            r_tw_addr <= '0;
                        end
                    end
                end
                S_CAPT: begin
                    r_res_re   <= {cm_out1[38], cm_out1} - {cm_out2[38], cm_out2};
                    r_res_im   <= {cm_out3[38], cm_out3} + {cm_out4[38], cm_out4};
                    r_res_addr <= r_i[LOGN-1:0];
                end
                S_OUT: begin
                    if (res_ready) begin
                        r_i <= w_i_nxt;
                        r_t <= w_t_nxt;
                        // Addresses only move when another op is issued, so they hold otherwise.
                        if (w_next == S_ADDR) begin
                            r_rd_addr <= w_i_nxt[LOGN-1:0];
                            r_tw_addr <= w_t_nxt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_addr  = r_rd_addr;
    assign tw_addr  = r_tw_addr;
    assign res_re   = r_res_re;
    assign res_im   = r_res_im;
    assign res_addr = r_res_addr;

endmodule

// File: tb/tb_cmul_seq.sv
// Randomized self-checking bench for cmul_seq: models data memory, twiddle ROM and the
// two-stage complex multiplier, and predicts results/timing from plain arithmetic.
module tb_cmul_seq;

    localparam int LOGN = 4;
    localparam int N    = 16;

    logic        clk = 1'b0;
    logic        reset, start, res_ready;
    logic [4:0]  op_len;
    logic [3:0]  tw_step;
    logic [3:0]  rd_addr, tw_addr, res_addr;
    logic        cm_en, res_valid, busy, done;
    logic [38:0] cm_out1, cm_out2, cm_out3, cm_out4;
    logic [39:0] res_re, res_im;

    logic signed [18:0] mem_a [N];
    logic signed [18:0] mem_b [N];
    logic signed [19:0] rom_c [N];
    logic signed [19:0] rom_d [N];
    logic signed [18:0] q_a, q_b, op_a, op_b;
    logic signed [19:0] q_c, q_d, op_c, op_d;
    logic signed [38:0] p1, p2, p3, p4;
    logic signed [38:0] ov1, ov2, ov3, ov4;
    logic               stg;
    logic               ovr;

    int n_chk = 0;
    int n_err = 0;

    cmul_seq #(.LOGN(LOGN)) dut (
        .clk(clk), .reset(reset), .start(start), .op_len(op_len), .tw_step(tw_step),
        .rd_addr(rd_addr), .tw_addr(tw_addr), .cm_en(cm_en),
        .cm_out1(cm_out1), .cm_out2(cm_out2), .cm_out3(cm_out3), .cm_out4(cm_out4),
        .res_re(res_re), .res_im(res_im), .res_addr(res_addr),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Environment: 1-cycle sync-read memories and a multiplier that registers operands on cm_en
    // and presents products two edges later.
    always @(posedge clk) begin
        if (reset) begin
            stg <= 1'b0;
            p1 <= '0; p2 <= '0; p3 <= '0; p4 <= '0;
        end else begin
            q_a <= mem_a[rd_addr];
            q_b <= mem_b[rd_addr];
            q_c <= rom_c[tw_addr];
            q_d <= rom_d[tw_addr];
            if (cm_en) begin
                op_a <= q_a; op_b <= q_b; op_c <= q_c; op_d <= q_d;
            end
            stg <= cm_en;
            if (stg) begin
                p1 <= 39'(op_a) * 39'(op_c);
                p2 <= 39'(op_b) * 39'(op_d);
                p3 <= 39'(op_b) * 39'(op_c);
                p4 <= 39'(op_a) * 39'(op_d);
            end
        end
    end

    assign cm_out1 = ovr ? ov1 : p1;
    assign cm_out2 = ovr ? ov2 : p2;
    assign cm_out3 = ovr ? ov3 : p3;
    assign cm_out4 = ovr ? ov4 : p4;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint m_re(int k, int step);
        int t;
        t = (k * step) % N;
        if (ovr) return longint'(ov1) - longint'(ov2);
        return longint'(mem_a[k]) * longint'(rom_c[t]) - longint'(mem_b[k]) * longint'(rom_d[t]);
    endfunction

    function automatic longint m_im(int k, int step);
        int t;
        t = (k * step) % N;
        if (ovr) return longint'(ov3) + longint'(ov4);
        return longint'(mem_b[k]) * longint'(rom_c[t]) + longint'(mem_a[k]) * longint'(rom_d[t]);
    endfunction

    // Runs one block; stalls op stall_k for stall_n cycles; optionally pokes start while busy.
    task automatic run_block(input int len_in, input int step, input int stall_k,
                             input int stall_n, input bit poke);
        int len, k, cyc, stall_left, en_cnt, done_cyc, exp_cyc, extra;
        bit first;
        len = (len_in > N) ? N : len_in;
        extra = (stall_k < len) ? stall_n : 0;
        op_len = 5'(len_in);
        tw_step = 4'(step);
        start = 1'b1;
        res_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; k = 0; en_cnt = 0; done_cyc = -1; stall_left = stall_n; first = 1'b1;
        while (cyc < 5 * len + stall_n + 20 && done_cyc < 0) begin
            start = (poke && cyc == 1) ? 1'b1 : 1'b0;
            if (poke && cyc == 1) begin
                op_len = 5'd7;
                tw_step = 4'd5;
            end
            chk("busy", busy, 1);
            if (cm_en) begin
                en_cnt++;
                chk("rd_addr", rd_addr, k);
                chk("tw_addr", tw_addr, (k * step) % N);
            end
            res_ready = 1'b1;
            if (res_valid) begin
                if (first) begin
                    exp_cyc = 5 * k + 5 + ((k > stall_k) ? stall_n : 0);
                    chk("valid_cycle", cyc, exp_cyc);
                    first = 1'b0;
                end
                chk("res_addr", res_addr, k);
                chk("res_re", longint'($signed(res_re)), m_re(k, step));
                chk("res_im", longint'($signed(res_im)), m_im(k, step));
                if (k == stall_k && stall_left > 0) begin
                    res_ready = 1'b0;
                    stall_left--;
                end else begin
                    k++;
                    first = 1'b1;
                end
            end
            if (done) done_cyc = cyc;
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("done_cycle", done_cyc, 5 * len + 1 + extra);
        chk("result_count", k, len);
        chk("cm_en_count", en_cnt, len);
        chk("idle_busy", busy, 0);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        int qv;
        reset = 1'b1; start = 1'b0; res_ready = 1'b1; op_len = '0; tw_step = '0;
        ovr = 1'b0; ov1 = '0; ov2 = '0; ov3 = '0; ov4 = '0;
        for (int j = 0; j < N; j++) begin
            mem_a[j] = 19'($urandom); mem_b[j] = 19'($urandom);
            rom_c[j] = 20'($urandom); rom_d[j] = 20'($urandom);
        end
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {rd_addr, tw_addr, res_addr, cm_en, res_valid, done}, 0);
        chk("rst_res", res_re | res_im, 0);
        reset = 1'b0;
        tick();

        // Single op with known small operands.
        mem_a[0] = 19'sd3; mem_b[0] = 19'sd2; rom_c[0] = 20'sd1; rom_d[0] = 20'sd4;
        run_block(1, 0, 99, 0, 1'b0);
        chk("single_re_const", m_re(0, 0), -5);
        chk("single_im_const", m_im(0, 0), 14);

        // Full block with stride 3 wrapping modulo 16.
        run_block(16, 3, 99, 0, 1'b0);
        // Backpressure on op 2 for 7 cycles, with a start poke while busy.
        run_block(5, 7, 2, 7, 1'b1);
        // Extreme products through the override path.
        ovr = 1'b1;
        ov1 = 39'sh40_0000_0000; ov2 = 39'sh3F_FFFF_FFFF;
        ov3 = 39'sh40_0000_0000; ov4 = 39'sh40_0000_0000;
        run_block(1, 0, 99, 0, 1'b0);
        chk("ext_re_abs", m_re(0, 0), -(64'sd1 <<< 39) + 1);
        chk("ext_im_abs", m_im(0, 0), -(64'sd1 <<< 39));
        ovr = 1'b0;
        // Empty block and clamped length.
        run_block(0, 2, 99, 0, 1'b1);
        run_block(20, 5, 99, 0, 1'b0);
        // Random blocks with random stalls.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < N; j++) begin
                mem_a[j] = 19'($urandom); mem_b[j] = 19'($urandom);
                rom_c[j] = 20'($urandom); rom_d[j] = 20'($urandom);
            end
            run_block($urandom_range(1, 16), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 4), 1'b0);
        end

        // Reset asserted during WAIT of op index 5.
        op_len = 5'd8; tw_step = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 28; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_outs", {rd_addr, tw_addr, res_addr, cm_en, res_valid, done, busy}, 0);
        chk("mid_rst_res", res_re | res_im, 0);
        qv = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || res_valid || busy) qv++;
            tick();
        end
        chk("post_rst_quiet", qv, 0);
        run_block(6, 5, 99, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
